// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller of a dual-clock asynchronous FIFO.
// Lives entirely in the rclk domain. The Gray write pointer is brought in
// through a two-flop synchroniser. The binary and Gray read pointers, the
// empty/almost-empty/underflow flags and a conservative fill level are all
// produced from registers.
module fifo_read_ctrl #(
  parameter int ADDRSIZE            = 4,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  // Pointer width: one extra bit to tell full from empty.
  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

  // Binary to reflected Gray code.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Reflected Gray code back to binary: each bit is the XOR of all
  // Gray bits at and above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] gray);
    logic [PW-1:0] bin;
    bin[PW-1] = gray[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Synchroniser stages for the incoming write pointer.
  logic [PW-1:0] rq1_wptr_r;
  logic [PW-1:0] rq2_wptr_r;

  // Read pointer state and registered outputs.
  logic [PW-1:0] rbin_r;
  logic [PW-1:0] rptr_r;
  logic          rempty_r;
  logic          arempty_r;
  logic [PW-1:0] rlevel_r;
  logic          runderflow_r;

  // Next-state values.
  logic          ren_s;
  logic [PW-1:0] rbinnext_s;
  logic [PW-1:0] rgraynext_s;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] lvl_next_s;
  logic          rempty_next_s;
  logic          arempty_next_s;
  logic          runderflow_next_s;

  // Two-flop synchroniser: wptr is only ever sampled here, so a single-bit
  // Gray change resolves to either the old or the new pointer value.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_wptr_r <= {PW{1'b0}};
      rq2_wptr_r <= {PW{1'b0}};
    end else begin
      rq1_wptr_r <= wptr;
      rq2_wptr_r <= rq1_wptr_r;
    end
  end

  // Next-state logic: pop acceptance, pointer advance, level and flags.
  always_comb begin
    ren_s             = 1'b0;
    rbinnext_s        = rbin_r;
    rgraynext_s       = rptr_r;
    wbin_s            = {PW{1'b0}};
    lvl_next_s        = {PW{1'b0}};
    rempty_next_s     = 1'b1;
    arempty_next_s    = 1'b1;
    runderflow_next_s = 1'b0;

    // A pop is taken only while the FIFO looks non-empty; a request against
    // an empty FIFO is dropped and flagged instead of moving the pointer.
    ren_s             = rinc & ~rempty_r;
    runderflow_next_s = rinc & rempty_r;

    // Natural modulo-2**PW wrap: raddr rolls over and the MSB toggles.
    rbinnext_s  = rbin_r + {{ADDRSIZE{1'b0}}, ren_s};
    rgraynext_s = bin2gray(rbinnext_s);

    // Level is measured against the synchronised write pointer, so it can
    // only lag the true occupancy, never overstate it.
    wbin_s     = gray2bin(rq2_wptr_r);
    lvl_next_s = wbin_s - rbinnext_s;

    // Empty compares in Gray so it agrees exactly with lvl_next_s == 0.
    rempty_next_s  = (rgraynext_s == rq2_wptr_r);
    arempty_next_s = (lvl_next_s <= AE_THRESH);
  end

  // Read pointer registers: binary drives the RAM, Gray goes to the
  // write domain.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
    end else begin
      rbin_r <= rbinnext_s;
      rptr_r <= rgraynext_s;
    end
  end

  // Status registers: flags and level update on the same edge so that
  // rempty and rlevel == 0 always agree.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rempty_r     <= 1'b1;
      arempty_r    <= 1'b1;
      rlevel_r     <= {PW{1'b0}};
      runderflow_r <= 1'b0;
    end else begin
      rempty_r     <= rempty_next_s;
      arempty_r    <= arempty_next_s;
      rlevel_r     <= lvl_next_s;
      runderflow_r <= runderflow_next_s;
    end
  end

  // RAM address is a plain slice of the binary register.
  assign raddr      = rbin_r[ADDRSIZE-1:0];
  assign rptr       = rptr_r;
  assign rempty     = rempty_r;
  assign arempty    = arempty_r;
  assign rlevel     = rlevel_r;
  assign runderflow = runderflow_r;

endmodule
